// File: rtl/rca_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// rca_addsub_arbiter
//   Two-port round-robin arbiter and sequencer for one shared WIDTH-bit
//   ripple-carry adder/subtractor.
//   Sequence: IDLE (accept) -> EXEC (compute) -> RESP (hold result).
//
//   Parameters
//     WIDTH       operand/result width (>= 2)
//
//   Ports
//     clk, rst_n                    clock, asynchronous active-low reset
//     reqN_valid/reqN_ready         request handshake, N = 0, 1
//     reqN_a, reqN_b, reqN_sub      operands; sub = 1 selects A - B
//     res_valid/res_ready           result handshake
//     res_sum, res_cout, res_id     registered sum, carry-out, requester id
//     res_ovf                       signed overflow (only with the macro)
//
//   Build option
//     RCA_ADDSUB_OVF_EN  adds the res_ovf output and its overflow register.
// ---------------------------------------------------------------------------
module rca_addsub_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
`ifdef RCA_ADDSUB_OVF_EN
    ,
    output logic             res_ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] op_a, op_b;
    logic             op_sub, op_id;
    logic             last_id;
    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    // Round robin: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_id;
        else if (req1_valid)
            grant = 1'b1;
    end

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // ---- next-state logic ----
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req0_valid || req1_valid) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---- output logic ----
    // Ready is also gated by rst_n so both readys read 0 while reset is held.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = rst_n & req0_valid & ~grant;
                req1_ready = rst_n & req1_valid &  grant;
            end
            RESP:    res_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept = req0_ready | req1_ready;

    // Operand capture and arbitration history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            op_sub  <= 1'b0;
            op_id   <= 1'b0;
            last_id <= 1'b1;
        end else if (accept) begin
            op_a    <= grant ? req1_a   : req0_a;
            op_b    <= grant ? req1_b   : req0_b;
            op_sub  <= grant ? req1_sub : req0_sub;
            op_id   <= grant;
            last_id <= grant;
        end
    end

    // Shared ripple-carry unit: subtract is A + ~B + 1
    assign b_eff = op_b ^ {WIDTH{op_sub}};

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = op_sub;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i]     = op_a[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (op_a[i] & b_eff[i]) | (op_a[i] & carry[i]) | (b_eff[i] & carry[i]);
        end
    end

    // Result registers load only in EXEC, so they stay stable through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sum  <= '0;
            res_cout <= 1'b0;
            res_id   <= 1'b0;
        end else if (state == EXEC) begin
            res_sum  <= sum;
            res_cout <= carry[WIDTH];
            res_id   <= op_id;
        end
    end

`ifdef RCA_ADDSUB_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            res_ovf <= 1'b0;
        else if (state == EXEC)
            res_ovf <= carry[WIDTH] ^ carry[WIDTH-1];
    end
`else
    // No overflow output in this build.
`endif

endmodule
